// File: rtl/seg7_scan_ctrl.sv
// Bus-writable multiplexed 7-segment controller with refresh divider,
// anti-ghosting blank window, leading-zero suppression and global blank.
module seg7_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 20000,
    parameter int BLANK_CYC = 200
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic [DIGITS-1:0] led_en_o,
    output logic [7:0]        led_c_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [DW-1:0] BLK_END = DW'(BLANK_CYC);

    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   digen_q;
    logic [DIGITS-1:0]   dp_q;
    logic [1:0]          ctrl_q;
    logic [DW-1:0]       div_cnt;
    logic [IW-1:0]       idx;

    logic [DIGITS-1:0]   en_d;
    logic [7:0]          seg_d;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_en;
    logic                cur_zero;
    logic                zero_acc;
    logic                supp;
    logic                off;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Walk digits from the top so zero_acc tells whether digit i and
    // everything above it is zero when digit i is the selected one.
    always_comb begin
        zero_acc = 1'b1;
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_zero = 1'b0;
        en_d     = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc = zero_acc & (data_q[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur_nib  = data_q[4*i +: 4];
                cur_dp   = dp_q[i];
                cur_en   = digen_q[i];
                cur_zero = zero_acc;
                en_d[i]  = 1'b0;
            end
        end
        supp  = ctrl_q[0] & (idx != '0) & cur_zero & ~cur_dp;
        off   = (div_cnt < BLK_END) | ctrl_q[1] | ~cur_en | supp;
        seg_d = {hex7(cur_nib), ~cur_dp};
        if (off) begin
            en_d  = '1;
            seg_d = 8'hFF;
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (addr_i)
            2'd0: rdata_o[4*DIGITS-1:0] = data_q;
            2'd1: rdata_o[DIGITS-1:0]   = digen_q;
            2'd2: rdata_o[DIGITS-1:0]   = dp_q;
            2'd3: rdata_o[1:0]          = ctrl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            data_q   <= '0;
            digen_q  <= '1;
            dp_q     <= '0;
            ctrl_q   <= '0;
            div_cnt  <= '0;
            idx      <= '0;
            led_en_o <= '1;
            led_c_o  <= 8'hFF;
        end else begin
            if (we_i) begin
                unique case (addr_i)
                    2'd0: data_q  <= wdata_i[4*DIGITS-1:0];
                    2'd1: digen_q <= wdata_i[DIGITS-1:0];
                    2'd2: dp_q    <= wdata_i[DIGITS-1:0];
                    2'd3: ctrl_q  <= wdata_i[1:0];
                endcase
            end
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            led_en_o <= en_d;
            led_c_o  <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a pin model predicts every cycle,
// plus fixed-value checks for the key display scenarios.
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 8;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;

    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk;
    logic        rst_i;
    logic        we_i;
    logic [1:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [7:0]  led_en_o;
    logic [7:0]  led_c_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] m_data;
    logic [7:0]  m_digen;
    logic [7:0]  m_dp;
    logic [1:0]  m_ctrl;
    int          m_div;
    int          m_idx;
    logic [15:0] sb [$];

    seg7_scan_ctrl #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk),
        .rst_i(rst_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .led_en_o(led_en_o),
        .led_c_o(led_c_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [31:0] sh;
        logic        off;
        sh  = m_data >> (4 * m_idx);
        off = (m_div < BLANK_CYC) || m_ctrl[1] || !m_digen[m_idx] ||
              (m_ctrl[0] && m_idx != 0 && !m_dp[m_idx] && sh == 0);
        if (off) return 16'hFFFF;
        return {~(8'd1 << m_idx), HEX[sh[3:0]], ~m_dp[m_idx]};
    endfunction

    task automatic model_reset();
        m_data  = '0;
        m_digen = 8'hFF;
        m_dp    = '0;
        m_ctrl  = '0;
        m_div   = 0;
        m_idx   = 0;
        sb.delete();
    endtask

    task automatic tick();
        logic [15:0] e;
        sb.push_back(model_out());
        @(posedge clk);
        if (we_i) begin
            case (addr_i)
                2'd0: m_data  = wdata_i;
                2'd1: m_digen = wdata_i[7:0];
                2'd2: m_dp    = wdata_i[7:0];
                default: m_ctrl = wdata_i[1:0];
            endcase
        end
        if (m_div == SCAN_DIV - 1) begin
            m_div = 0;
            m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
        end else begin
            m_div++;
        end
        cyc++;
        #1;
        e = sb.pop_front();
        check("pins", {16'h0, led_en_o, led_c_o}, {16'h0, e});
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d, logic [31:0] rexp);
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick();
        we_i = 1'b0;
        #1;
        check("readback", rdata_o, rexp);
    endtask

    task automatic wait_en(string tag, logic [7:0] v, bit eq);
        int n = 0;
        while (((led_en_o == v) != eq) && n < 64) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 64), 32'd1);
    endtask

    task automatic show(int d, logic [7:0] seg, string tag);
        wait_en(tag, ~(8'd1 << d), 1'b1);
        check(tag, 32'(led_c_o), 32'(seg));
    endtask

    task automatic frame(int n, output logic [7:0] seen);
        seen = '0;
        repeat (n) begin
            tick();
            seen |= ~led_en_o;
        end
    endtask

    initial begin
        logic [7:0] plan [6];
        logic [7:0] seen;
        int         t0;
        plan = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD};
        rst_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 2'd1;
        wdata_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 32'(led_en_o), 32'hFF);
        check("rst_seg", 32'(led_c_o), 32'hFF);
        check("rst_digen", rdata_o, 32'h0000_00FF);
        addr_i = 2'd0;
        #1;
        check("rst_data", rdata_o, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;

        for (int k = 0; k < 6; k++) begin
            tick();
            check("rel_en", 32'(led_en_o), 32'(plan[k]));
        end

        wr(2'd0, 32'h0000_0810, 32'h0000_0810);
        show(0, 8'h03, "d0_zero");
        show(1, 8'h9F, "d1_one");
        show(2, 8'h01, "d2_eight");
        for (int d = 3; d < 8; d++) show(d, 8'h03, "dhi_zero");

        wr(2'd3, 32'h0000_0001, 32'h0000_0001);
        frame(32, seen);
        check("lzs_seen", 32'(seen), 32'h07);

        wr(2'd2, 32'hABCD_EF08, 32'h0000_0008);
        show(3, 8'h02, "d3_dp");

        wr(2'd1, 32'h0000_00FE, 32'h0000_00FE);
        frame(32, seen);
        check("digen_seen", 32'(seen), 32'h0E);
        wait_en("per_a", 8'hFD, 1'b0);
        wait_en("per_b", 8'hFD, 1'b1);
        t0 = cyc;
        wait_en("per_c", 8'hFD, 1'b0);
        wait_en("per_d", 8'hFD, 1'b1);
        check("period", 32'(cyc - t0), 32'd32);

        wr(2'd3, 32'h0000_0002, 32'h0000_0002);
        frame(32, seen);
        check("blank_seen", 32'(seen), 32'h00);
        wr(2'd3, 32'h0000_0000, 32'h0000_0000);
        frame(8, seen);

        wr(2'd1, 32'hFFFF_FFFF, 32'h0000_00FF);
        show(5, 8'h03, "pre_rst_d5");
        #2;
        rst_i  = 1'b0;
        addr_i = 2'd1;
        #1;
        check("mid_rst_en", 32'(led_en_o), 32'hFF);
        check("mid_rst_seg", 32'(led_c_o), 32'hFF);
        check("mid_rst_digen", rdata_o, 32'h0000_00FF);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        tick();
        check("post_rst_blank", 32'(led_en_o), 32'hFF);
        tick();
        check("post_rst_d0", 32'(led_en_o), 32'hFE);
        check("post_rst_seg", 32'(led_c_o), 32'h03);
        frame(32, seen);
        check("post_rst_seen", 32'(seen), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
